// File: rtl/sha_mem_responder.sv
// Word-addressed memory serving the SHA-256 engine's memory port, with a host
// load/unload port and a tracker that flags when all hash words have been written back.
module sha_mem_responder #(
  parameter int DEPTH      = 256,
  parameter int HASH_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] memory_addr,
  input  logic        enable_write,
  input  logic [31:0] memory_write_data,
  output logic [31:0] memory_read_data,
  input  logic        engine_busy,
  input  logic [15:0] hash_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        result_valid,
  output logic        err_oob
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH];

  logic        rd_en;
  logic        wr_en;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_in_range;
  logic        wr_in_range;
  logic [31:0] rd_word;

  logic [31:0] mem_rdata_d, mem_rdata_q;
  logic [31:0] host_rdata_d, host_rdata_q;
  logic        host_rvalid_d, host_rvalid_q;
  logic        err_oob_d, err_oob_q;
  logic        busy_d, busy_q;
  logic        result_valid_d, result_valid_q;
  state_t      state_d, state_q;
  logic [HASH_WORDS-1:0] mask_d, mask_q;

  logic        busy_rise;
  logic [16:0] eng_addr_x;
  logic [16:0] hash_lo_x;
  logic [16:0] hash_hi_x;
  logic        hash_hit;
  logic [15:0] hash_off;
  logic [HASH_WORDS-1:0] hash_bit;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[15:AW], wr_addr[15:AW]};

  // Single port: an engine write or a non-granted cycle always belongs to the engine.
  always_comb begin
    host_gnt    = host_req & ~engine_busy & ~enable_write;
    rd_en       = ~host_gnt | ~host_we;
    rd_addr     = host_gnt ? host_addr : memory_addr;
    wr_en       = enable_write | (host_gnt & host_we);
    wr_addr     = enable_write ? memory_addr : host_addr;
    wr_data     = enable_write ? memory_write_data : host_wdata;
    rd_in_range = {1'b0, rd_addr} < 17'(DEPTH);
    wr_in_range = {1'b0, wr_addr} < 17'(DEPTH);
    rd_word     = rd_in_range ? mem[rd_addr[AW-1:0]] : 32'h0;
  end

  always_comb begin
    mem_rdata_d   = host_gnt ? mem_rdata_q : rd_word;
    host_rvalid_d = host_gnt & ~host_we;
    host_rdata_d  = host_rvalid_d ? rd_word : host_rdata_q;
    err_oob_d     = err_oob_q | (rd_en & ~rd_in_range) | (wr_en & ~wr_in_range);
  end

  // Hash window compare is done in 17 bits so hash_addr + HASH_WORDS cannot wrap.
  always_comb begin
    busy_d     = engine_busy;
    busy_rise  = engine_busy & ~busy_q;
    eng_addr_x = {1'b0, memory_addr};
    hash_lo_x  = {1'b0, hash_addr};
    hash_hi_x  = {1'b0, hash_addr} + 17'(HASH_WORDS);
    hash_hit   = enable_write & (eng_addr_x >= hash_lo_x) & (eng_addr_x < hash_hi_x);
    hash_off   = memory_addr - hash_addr;
    hash_bit   = HASH_WORDS'(1) << hash_off;

    state_d = state_q;
    mask_d  = mask_q;
    if (busy_rise) begin
      state_d = RUN;
      mask_d  = '0;
    end else if (state_q == RUN && hash_hit) begin
      mask_d = mask_q | hash_bit;
      if (&mask_d) state_d = DONE;
    end
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata_q    <= '0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      err_oob_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      state_q        <= IDLE;
      mask_q         <= '0;
    end else begin
      mem_rdata_q    <= mem_rdata_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      err_oob_q      <= err_oob_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      state_q        <= state_d;
      mask_q         <= mask_d;
    end
  end

  assign memory_read_data = mem_rdata_q;
  assign host_rdata       = host_rdata_q;
  assign host_rvalid      = host_rvalid_q;
  assign result_valid     = result_valid_q;
  assign err_oob          = err_oob_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Randomized self-checking bench for sha_mem_responder against a behavioural model.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] memory_addr;
  logic        enable_write;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        engine_busy;
  logic [15:0] hash_addr;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        result_valid;
  logic        err_oob;

  sha_mem_responder #(.DEPTH(256), .HASH_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .memory_addr(memory_addr), .enable_write(enable_write),
    .memory_write_data(memory_write_data), .memory_read_data(memory_read_data),
    .engine_busy(engine_busy), .hash_addr(hash_addr),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .result_valid(result_valid), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural reference: memory contents, output registers, and a set of
  // hash words seen since the last start of a run.
  logic [31:0] m_mem [256];
  logic [31:0] load_val [256];
  logic [31:0] m_mrd, m_hrd;
  bit          m_hrv, m_oob, m_prev_busy, m_running, m_done;
  bit          m_seen [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mrd = '0; m_hrd = '0; m_hrv = 0; m_oob = 0;
    m_prev_busy = 0; m_running = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_seen[i] = 0;
  endtask

  task automatic model_step();
    bit gnt, all_seen;
    int ra, wa, off;
    logic [31:0] rv, wd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gnt = host_req && !engine_busy && !enable_write;
    ra  = gnt ? int'(host_addr) : int'(memory_addr);
    rv  = (ra < 256) ? m_mem[ra] : 32'h0;
    if ((!gnt || !host_we) && ra >= 256) m_oob = 1;
    if (!gnt) m_mrd = rv;
    m_hrv = gnt && !host_we;
    if (m_hrv) m_hrd = rv;

    if (engine_busy && !m_prev_busy) begin
      m_running = 1; m_done = 0;
      for (int i = 0; i < 8; i++) m_seen[i] = 0;
    end else if (m_running && !m_done && enable_write) begin
      off = int'(memory_addr) - int'(hash_addr);
      if (off >= 0 && off < 8) begin
        m_seen[off] = 1;
        all_seen = 1;
        for (int i = 0; i < 8; i++) if (!m_seen[i]) all_seen = 0;
        if (all_seen) m_done = 1;
      end
    end
    m_prev_busy = engine_busy;

    wa = -1; wd = '0;
    if (enable_write) begin
      wa = int'(memory_addr); wd = memory_write_data;
    end else if (gnt && host_we) begin
      wa = int'(host_addr); wd = host_wdata;
    end
    if (wa >= 256) m_oob = 1;
    else if (wa >= 0) m_mem[wa] = wd;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("memory_read_data", memory_read_data, m_mrd);
    chk("host_rdata", host_rdata, m_hrd);
    chk("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
    chk("result_valid", 32'(result_valid), 32'(m_done));
    chk("err_oob", 32'(err_oob), 32'(m_oob));
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    host_req = 1; host_we = 1; host_addr = 16'(a); host_wdata = d;
    #1;
    chk("host_gnt_write", 32'(host_gnt), 32'(!engine_busy && !enable_write));
    cyc();
    host_req = 0;
  endtask

  task automatic host_read(input int a);
    host_req = 1; host_we = 0; host_addr = 16'(a);
    cyc();
    host_req = 0;
  endtask

  task automatic eng_write(input int a, input logic [31:0] d);
    enable_write = 1; memory_addr = 16'(a); memory_write_data = d;
    cyc();
    enable_write = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    rst_n = 0; memory_addr = '0; enable_write = 0; memory_write_data = '0;
    engine_busy = 0; hash_addr = 16'd100; host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_mrd", memory_read_data, 32'h0);
    chk("rst_hrd", host_rdata, 32'h0);
    chk("rst_hrv", 32'(host_rvalid), 32'h0);
    chk("rst_result", 32'(result_valid), 32'h0);
    chk("rst_oob", 32'(err_oob), 32'h0);
    chk("rst_gnt", 32'(host_gnt), 32'h0);
    rst_n = 1;

    // Host load: 0..39 with the fixed pattern, the rest random.
    for (int i = 0; i < 256; i++) begin
      d = (i < 40) ? 32'h0001_0000 + 32'(i) : $urandom;
      load_val[i] = d;
      host_write(i, d);
    end
    host_read(39);
    chk("hr39_valid", 32'(host_rvalid), 32'h1);
    chk("hr39_data", host_rdata, 32'h0001_0027);
    chk("hr39_oob", 32'(err_oob), 32'h0);
    cyc();
    chk("hr39_pulse", 32'(host_rvalid), 32'h0);

    // Engine read latency.
    engine_busy = 1; memory_addr = 16'd5;
    cyc();
    chk("lat5", memory_read_data, 32'h0001_0005);
    memory_addr = 16'd6;
    cyc();
    chk("lat6", memory_read_data, 32'h0001_0006);
    engine_busy = 0; memory_addr = '0;
    cyc();

    // Hash write-back with read-during-write and near-miss addresses.
    hash_addr = 16'd100; engine_busy = 1;
    cyc();
    eng_write(100, 32'hA5A5_0100);
    chk("rdw_old", memory_read_data, load_val[100]);
    eng_write(99, 32'h1111_0099);
    chk("miss99", 32'(result_valid), 32'h0);
    eng_write(108, 32'h1111_0108);
    chk("miss108", 32'(result_valid), 32'h0);
    for (int i = 1; i < 8; i++) begin
      eng_write(100 + i, 32'hA5A5_0100 + 32'(i));
      chk("hash_progress", 32'(result_valid), 32'(i == 7));
    end
    engine_busy = 0; memory_addr = '0;
    cyc();
    chk("result_sticky", 32'(result_valid), 32'h1);
    engine_busy = 1;
    cyc();
    chk("result_clear", 32'(result_valid), 32'h0);
    engine_busy = 0;
    cyc();

    // Arbitration: busy rising together with a host write.
    engine_busy = 1; host_req = 1; host_we = 1; host_addr = 16'd50;
    host_wdata = 32'hDEAD_0050; memory_addr = 16'd50;
    #1;
    chk("arb_deny", 32'(host_gnt), 32'h0);
    cyc();
    chk("arb_unchanged", memory_read_data, load_val[50]);
    cyc();
    engine_busy = 0;
    #1;
    chk("arb_grant", 32'(host_gnt), 32'h1);
    cyc();
    host_req = 0; memory_addr = '0;
    host_read(50);
    chk("arb_landed", host_rdata, 32'hDEAD_0050);

    // Out-of-range host read.
    host_read(256);
    chk("oob_rdata", host_rdata, 32'h0);
    chk("oob_flag", 32'(err_oob), 32'h1);
    for (int i = 0; i < 3; i++) cyc();
    chk("oob_sticky", 32'(err_oob), 32'h1);

    // Mid-run reset after four hash writes.
    hash_addr = 16'd100; engine_busy = 1;
    cyc();
    for (int i = 0; i < 4; i++) eng_write(100 + i, 32'hCAFE_0000 + 32'(i));
    #2;
    rst_n = 0;
    #1;
    chk("mrst_result", 32'(result_valid), 32'h0);
    chk("mrst_oob", 32'(err_oob), 32'h0);
    chk("mrst_mrd", memory_read_data, 32'h0);
    model_reset();
    cyc();
    rst_n = 1;
    cyc();
    for (int i = 4; i < 8; i++) eng_write(100 + i, 32'hCAFE_0000 + 32'(i));
    chk("mrst_mask_clear", 32'(result_valid), 32'h0);
    engine_busy = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      host_read(100 + i);
      chk("mrst_retained", host_rdata, 32'hCAFE_0000 + 32'(i));
    end

    // Randomized engine runs interleaved with host traffic.
    for (int r = 0; r < 20; r++) begin
      hash_addr = 16'($urandom_range(0, 248));
      engine_busy = 1; enable_write = 0; host_req = 0;
      cyc();
      for (int c = 0; c < 60 && !m_done; c++) begin
        enable_write = 0; host_req = 0;
        case ($urandom_range(0, 3))
          0: begin
            enable_write = 1; memory_write_data = $urandom;
            memory_addr = hash_addr + 16'($urandom_range(0, 7));
          end
          1: begin
            enable_write = 1; memory_write_data = $urandom;
            memory_addr = 16'($urandom_range(0, 255));
          end
          2: memory_addr = 16'($urandom_range(0, 255));
          default: begin
            memory_addr = 16'($urandom_range(0, 255));
            host_req = 1; host_we = 1'($urandom_range(0, 1));
            host_addr = 16'($urandom_range(0, 255)); host_wdata = $urandom;
          end
        endcase
        cyc();
      end
      enable_write = 0; host_req = 0; engine_busy = 0;
      for (int c = 0; c < 10; c++) begin
        host_req = 1'($urandom_range(0, 1));
        host_we = 1'($urandom_range(0, 1));
        host_addr = 16'($urandom_range(0, 263));
        host_wdata = $urandom;
        enable_write = ($urandom_range(0, 3) == 0);
        memory_addr = 16'($urandom_range(0, 255));
        memory_write_data = $urandom;
        cyc();
      end
      enable_write = 0; host_req = 0; memory_addr = '0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
